vga_draw_arbiter: RTL and testbench
===================================

Name: vga_draw_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, color, plot) between three drawing engines: screen clear (req 0), tile draw (req 1) and score/overlay draw (req 2).
- Grants one engine at a time using a level "go" that the engine holds its drawing on. The grant is held until that engine's done.
- Registers the winning engine's pixel stream onto the adapter.
- Guards every grant with a watchdog.

Parameters:
- TIMEOUT_CYCLES, 65535: maximum cycles a grant may last before it is revoked.
- WD_WIDTH, 16: width of the watchdog counter; must satisfy 2^WD_WIDTH > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  per-engine draw request, level; bit 0 highest priority.
- done  in  3  per-engine completion flag, level (engine holds it high until its go drops).
- eng_x  in  27  engine x coords, engine i at [9i+8:9i].
- eng_y  in  24  engine y coords, engine i at [8i+7:8i].
- eng_color  in  9  engine colors, engine i at [3i+2:3i].
- eng_plot  in  3  per-engine write enable.
- err_clear  in  1  clears timeout_err.
- go  out  3  one-hot grant to engines (at most one bit set).
- vga_x  out  9  registered x to adapter.
- vga_y  out  8  registered y to adapter.
- vga_color  out  3  registered color to adapter.
- vga_plot  out  1  registered write enable to adapter.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - While resetn=0: state=IDLE, go=0, vga_x=0, vga_y=0, vga_color=0, vga_plot=0, busy=0, timeout_err=0, watchdog=0, grant index g=0.
  - Reset asserted mid-grant drops go and vga_plot immediately; no drain is performed.
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If req != 0: g <= lowest set index of req, go <= onehot(g), watchdog <= 0, state <= GRANT.
  - Else: stay in IDLE.
  - vga_plot <= 0.
- GRANT:
  - Datapath: vga_x/y/color <= eng_*[g]; vga_plot <= eng_plot[g].
  - Non-granted engines' inputs, including their done and plot, are ignored.
  - Watchdog increments each cycle.
  - Exit conditions, checked in priority order:
    - (a) done[g]=1: go <= 0, vga_plot <= 0, state <= RELEASE. The pixel presented in the same cycle as done is dropped; engines must not plot in their done cycle.
    - (b) req[g]=0 (abort): go <= 0, vga_plot <= 0, state <= RELEASE.
    - (c) watchdog == TIMEOUT_CYCLES-1: go <= 0, vga_plot <= 0, timeout_err <= 1, state <= RELEASE.
  - done and timeout in the same cycle: done wins and no error is flagged.
- RELEASE:
  - go=0, vga_plot=0.
  - Stay until done[g]=0, then state <= IDLE. This guarantees the engine has seen go low and rearmed.
  - At least one RELEASE cycle always occurs, so there is at least one idle cycle between consecutive grants.
- Latency:
  - req high at IDLE edge N -> go high after edge N+1.
  - Engine pixel at edge M in GRANT -> on vga_* after edge M+1 (single register stage).
- Priority is fixed (0 > 1 > 2). A grant is never pre-empted: a higher-priority req arriving mid-grant waits for RELEASE->IDLE.
- timeout_err:
  - Set by watchdog expiry; cleared by err_clear=1.
  - Set and clear in the same cycle: set wins.
- busy = (state != IDLE), registered with the state.
- Coordinates pass through unchanged; the arbiter performs no range check.

Test Plan:
- Reset then idle: resetn low for 3 cycles, req=0 -> all outputs 0, busy=0, vga_plot never high.
- Single clear engine:
  - Stimulus: req=3'b001; engine 0 plots from x=120 at y=0, stepping x by 1 per cycle to 199; after 80 pixels, done[0]=1.
  - Required: go=001 one cycle after req; vga_x=120 one cycle after the first eng_x=120; 80 vga_plot pulses; go=000 the cycle after done; IDLE once done drops.
- Simultaneous requests:
  - Stimulus: req=3'b110 together.
  - Required: tile (go=010) is served first; score gets go=100 only after tile's done and one RELEASE cycle.
  - Engine 2's eng_plot pulses during tile's grant never reach vga_plot.
- No pre-emption: during the tile grant, assert req[0] -> go stays 010 until done[1]; go=001 is the next grant.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16, grant engine 1, never assert done.
  - Required: go drops after 16 GRANT cycles and timeout_err=1.
  - Then err_clear=1 -> timeout_err=0; with done and timeout coinciding in a rerun -> timeout_err stays 0.
- Reset mid-grant: pull resetn low during the engine 0 grant -> go=000 and vga_plot=0 asynchronously; after release, the arbiter restarts in IDLE and re-grants engine 0 if req[0] is still high.

Source files
------------

// File: rtl/vga_draw_arbiter_if.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter_if
// Bundles the engine-side request/pixel bus and the adapter-side pixel bus of
// the VGA draw arbiter.
//   req       [2:0]  per-engine draw request (level), bit 0 highest priority
//   done      [2:0]  per-engine completion flag (level)
//   eng_x     [26:0] engine i x at [9i+8:9i]
//   eng_y     [23:0] engine i y at [8i+7:8i]
//   eng_color [8:0]  engine i color at [3i+2:3i]
//   eng_plot  [2:0]  per-engine write enable
//   go        [2:0]  one-hot grant back to the engines
//   vga_x/vga_y/vga_color/vga_plot  registered pixel stream to the adapter
// slave  : the arbiter side
// master : the engines + adapter side (testbench)
// -----------------------------------------------------------------------------
interface vga_draw_arbiter_if;
   logic [2:0]  req;
   logic [2:0]  done;
   logic [26:0] eng_x;
   logic [23:0] eng_y;
   logic [8:0]  eng_color;
   logic [2:0]  eng_plot;
   logic [2:0]  go;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_color;
   logic        vga_plot;

   modport slave (
      input  req, done, eng_x, eng_y, eng_color, eng_plot,
      output go, vga_x, vga_y, vga_color, vga_plot
   );

   modport master (
      output req, done, eng_x, eng_y, eng_color, eng_plot,
      input  go, vga_x, vga_y, vga_color, vga_plot
   );
endinterface

// File: rtl/vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// vga_draw_arbiter
// Shares the single VGA adapter write port between three drawing engines
// (0 = screen clear, 1 = tile draw, 2 = score overlay). Fixed priority, no
// pre-emption: a grant lasts until the engine's done, an abort (req dropped)
// or watchdog expiry. The granted engine's pixel stream is registered once
// onto the adapter.
// Ports:
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   err_clear    clears timeout_err (a same-cycle timeout wins)
//   bus          vga_draw_arbiter_if.slave (req/done/eng_* in, go/vga_* out)
//   busy         high whenever the arbiter is not IDLE
//   timeout_err  sticky watchdog-expiry flag
// -----------------------------------------------------------------------------
module vga_draw_arbiter #(
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int WD_WIDTH       = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  err_clear,
   vga_draw_arbiter_if.slave     bus,
   output logic                  busy,
   output logic                  timeout_err
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t              state_reg;
   logic [1:0]          g_reg;
   logic [2:0]          go_reg;
   logic [8:0]          vga_x_reg;
   logic [7:0]          vga_y_reg;
   logic [2:0]          vga_color_reg;
   logic                vga_plot_reg;
   logic [WD_WIDTH-1:0] wd_reg;
   logic                busy_reg;
   logic                timeout_err_reg;

   // Per-engine views of the packed coordinate buses
   logic [8:0] x_slice     [3];
   logic [7:0] y_slice     [3];
   logic [2:0] color_slice [3];

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slice
         assign x_slice[gi]     = bus.eng_x[9*gi +: 9];
         assign y_slice[gi]     = bus.eng_y[8*gi +: 8];
         assign color_slice[gi] = bus.eng_color[3*gi +: 3];
      end
   endgenerate

   // Mux of the granted engine; compare-based so g never indexes out of range
   logic [8:0] sel_x;
   logic [7:0] sel_y;
   logic [2:0] sel_color;
   logic       sel_plot;
   logic       sel_done;
   logic       sel_req;

   always_comb begin
      sel_x     = '0;
      sel_y     = '0;
      sel_color = '0;
      sel_plot  = 1'b0;
      sel_done  = 1'b0;
      sel_req   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (g_reg == 2'(i)) begin
            sel_x     = x_slice[i];
            sel_y     = y_slice[i];
            sel_color = color_slice[i];
            sel_plot  = bus.eng_plot[i];
            sel_done  = bus.done[i];
            sel_req   = bus.req[i];
         end
      end
   end

   // Lowest set request index wins
   logic [1:0] first_idx;
   always_comb begin
      if (bus.req[0])      first_idx = 2'd0;
      else if (bus.req[1]) first_idx = 2'd1;
      else                 first_idx = 2'd2;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_reg       <= IDLE;
         g_reg           <= 2'd0;
         go_reg          <= 3'b000;
         vga_x_reg       <= '0;
         vga_y_reg       <= '0;
         vga_color_reg   <= '0;
         vga_plot_reg    <= 1'b0;
         wd_reg          <= '0;
         busy_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         // A watchdog expiry later in this block overrides the clear
         if (err_clear) timeout_err_reg <= 1'b0;

         case (state_reg)
            IDLE: begin
               go_reg       <= 3'b000;
               vga_plot_reg <= 1'b0;
               if (|bus.req) begin
                  g_reg     <= first_idx;
                  go_reg    <= 3'b001 << first_idx;
                  wd_reg    <= '0;
                  state_reg <= GRANT;
                  busy_reg  <= 1'b1;
               end
            end
            GRANT: begin
               vga_x_reg     <= sel_x;
               vga_y_reg     <= sel_y;
               vga_color_reg <= sel_color;
               vga_plot_reg  <= sel_plot;
               wd_reg        <= wd_reg + 1'b1;
               // done beats abort beats timeout; the pixel of the exit
               // cycle is dropped
               if (sel_done || !sel_req || wd_reg == WD_LAST) begin
                  go_reg       <= 3'b000;
                  vga_plot_reg <= 1'b0;
                  state_reg    <= RELEASE;
                  if (!sel_done && sel_req) timeout_err_reg <= 1'b1;
               end
            end
            RELEASE: begin
               go_reg       <= 3'b000;
               vga_plot_reg <= 1'b0;
               // Wait for the engine to acknowledge go low before re-arbitrating
               if (!sel_done) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg    <= IDLE;
               busy_reg     <= 1'b0;
               go_reg       <= 3'b000;
               vga_plot_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.go        = go_reg;
   assign bus.vga_x     = vga_x_reg;
   assign bus.vga_y     = vga_y_reg;
   assign bus.vga_color = vga_color_reg;
   assign bus.vga_plot  = vga_plot_reg;
   assign busy          = busy_reg;
   assign timeout_err   = timeout_err_reg;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_draw_arbiter
// Randomised engine stimulus with a pixel scoreboard: every plotted pixel an
// engine issues while granted is queued, and an independent monitor pops and
// compares on each adapter write. Grant order comes from a lowest-set-bit
// priority model; latencies and watchdog length are derived from the rules.
// -----------------------------------------------------------------------------
module tb_vga_draw_arbiter;

   localparam int TO = 90;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   logic clock;
   logic resetn;
   logic err_clear;
   logic busy;
   logic timeout_err;

   vga_draw_arbiter_if bus ();

   vga_draw_arbiter #(
      .TIMEOUT_CYCLES(TO),
      .WD_WIDTH      (7)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .err_clear  (err_clear),
      .bus        (bus.slave),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int   checks   = 0;
   int   failures = 0;
   int   plot_cnt = 0;
   pix_t sb[$];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   function automatic int lowest(logic [2:0] r);
      for (int i = 0; i < 3; i++) if (r[i]) return i;
      return -1;
   endfunction

   task automatic set_pix(int e, logic [8:0] x, logic [7:0] y, logic [2:0] c, logic p);
      bus.eng_x[9*e +: 9]     = x;
      bus.eng_y[8*e +: 8]     = y;
      bus.eng_color[3*e +: 3] = c;
      bus.eng_plot[e]         = p;
   endtask

   // Non-granted engines scribble pixels that must never reach the adapter
   task automatic noise(int e);
      for (int i = 0; i < 3; i++)
         if (i != e) set_pix(i, 9'($urandom), 8'($urandom), 3'($urandom), 1'($urandom_range(0, 1)));
   endtask

   // Monitor: one pop per adapter write
   always begin
      @(posedge clock);
      #1;
      chk("go_onehot", 32'($onehot0(bus.go)), 32'd1);
      if (resetn && bus.vga_plot) begin
         plot_cnt++;
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            pix_t exp_p;
            exp_p = sb.pop_front();
            chk("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_color}), 32'(exp_p));
         end
      end
   end

   task automatic wait_go(int e, int maxc, output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (bus.go == 3'b000 && n < maxc);
      chk("grant", 32'(bus.go), 32'(1 << e));
   endtask

   // Drive n pixels from granted engine e, then done; x0 >= 0 gives a run of
   // consecutive x from x0 at y=0 with every pixel plotted.
   task automatic serve(int e, int n, int x0, logic [2:0] raise_mask, int raise_at);
      int base;
      int plotted;
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
      logic       p;
      base    = plot_cnt;
      plotted = 0;
      for (int i = 0; i < n; i++) begin
         if (x0 >= 0) begin
            x = 9'(x0 + i);
            y = 8'd0;
            c = 3'($urandom);
            p = 1'b1;
         end else begin
            x = 9'($urandom);
            y = 8'($urandom);
            c = 3'($urandom);
            p = ($urandom_range(0, 3) != 0);
         end
         set_pix(e, x, y, c, p);
         noise(e);
         if (p) begin
            sb.push_back('{x, y, c});
            plotted++;
         end
         if (i == raise_at) bus.req = bus.req | raise_mask;
         cyc();
         if (i == 0 && x0 >= 0) chk("first_x", 32'(bus.vga_x), 32'(x0));
         chk("hold_go", 32'(bus.go), 32'(1 << e));
      end
      // Pixel presented alongside done must be dropped
      bus.done[e] = 1'b1;
      set_pix(e, 9'h1ff, 8'hff, 3'h7, 1'b1);
      noise(e);
      cyc();
      chk("go_drop", 32'(bus.go), 32'd0);
      chk("busy_release", 32'(busy), 32'd1);
      chk("plot_drop", 32'(bus.vga_plot), 32'd0);
      bus.done[e]  = 1'b0;
      bus.req[e]   = 1'b0;
      bus.eng_plot = 3'b000;
      cyc();
      chk("busy_idle", 32'(busy), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("plot_count", 32'(plot_cnt - base), 32'(plotted));
   endtask

   // mode 0: plain expiry, 1: err_clear on the expiry edge, 2: done on the expiry edge
   task automatic wd_run(int mode);
      int n;
      int cnt;
      bus.req = 3'b010;
      wait_go(1, 5, n);
      chk("wd_grant_lat", 32'(n), 32'd1);
      cnt = 1;
      for (int k = 0; k < TO + 5; k++) begin
         if (cnt == TO && mode == 1) err_clear = 1'b1;
         if (cnt == TO && mode == 2) bus.done[1] = 1'b1;
         cyc();
         err_clear = 1'b0;
         if (bus.go == 3'b010) cnt++;
         else break;
      end
      bus.req = 3'b000;
      chk("wd_grant_cycles", 32'(cnt), 32'(TO));
      chk("wd_err", 32'(timeout_err), (mode == 2) ? 32'd0 : 32'd1);
      bus.done[1] = 1'b0;
      cyc();
      cyc();
      chk("wd_busy_idle", 32'(busy), 32'd0);
      chk("wd_err_sticky", 32'(timeout_err), (mode == 2) ? 32'd0 : 32'd1);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      chk("wd_err_cleared", 32'(timeout_err), 32'd0);
   endtask

   initial begin
      int n;
      logic [2:0] pend;
      int e;
      resetn        = 1'b0;
      err_clear     = 1'b0;
      bus.req       = '0;
      bus.done      = '0;
      bus.eng_x     = '0;
      bus.eng_y     = '0;
      bus.eng_color = '0;
      bus.eng_plot  = '0;

      // Reset then idle
      cyc(); cyc(); cyc();
      chk("rst_go", 32'(bus.go), 32'd0);
      chk("rst_vga", 32'({bus.vga_x, bus.vga_y, bus.vga_color, bus.vga_plot}), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      resetn = 1'b1;
      cyc(); cyc(); cyc();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_go", 32'(bus.go), 32'd0);

      // Single clear engine: 80 pixels x=120..199
      bus.req = 3'b001;
      wait_go(0, 5, n);
      chk("clear_grant_lat", 32'(n), 32'd1);
      serve(0, 80, 120, 3'b000, -1);

      // Simultaneous tile + score
      bus.req = 3'b110;
      wait_go(1, 5, n);
      chk("tile_grant_lat", 32'(n), 32'd1);
      serve(1, $urandom_range(5, 20), -1, 3'b000, -1);
      wait_go(2, 5, n);
      chk("score_after_release", 32'(n), 32'd1);
      serve(2, $urandom_range(5, 20), -1, 3'b000, -1);

      // No pre-emption: req[0] raised mid tile grant
      bus.req = 3'b010;
      wait_go(1, 5, n);
      serve(1, 12, -1, 3'b001, 4);
      wait_go(0, 5, n);
      chk("next_grant_clear", 32'(n), 32'd1);
      serve(0, 8, -1, 3'b000, -1);

      // Random request patterns against the priority model
      for (int r = 0; r < 8; r++) begin
         pend    = 3'($urandom_range(1, 7));
         bus.req = pend;
         while (pend != 3'b000) begin
            e = lowest(pend);
            wait_go(e, 5, n);
            chk("rand_grant_lat", 32'(n), 32'd1);
            serve(e, $urandom_range(1, 20), -1, 3'b000, -1);
            pend[e] = 1'b0;
         end
      end

      // Watchdog
      wd_run(0);
      wd_run(1);
      wd_run(2);

      // Reset mid-grant
      bus.req = 3'b001;
      wait_go(0, 5, n);
      for (int i = 0; i < 4; i++) begin
         logic [8:0] x;
         x = 9'($urandom);
         set_pix(0, x, 8'd7, 3'd5, 1'b1);
         sb.push_back('{x, 8'd7, 3'd5});
         cyc();
      end
      bus.eng_plot = 3'b000;
      #2;
      resetn = 1'b0;
      #1;
      chk("async_go", 32'(bus.go), 32'd0);
      chk("async_plot", 32'(bus.vga_plot), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("rst_sb_empty", 32'(sb.size()), 32'd0);
      cyc();
      cyc();
      chk("rst_hold_go", 32'(bus.go), 32'd0);
      resetn = 1'b1;
      wait_go(0, 5, n);
      chk("regrant_lat", 32'(n), 32'd1);
      serve(0, 6, -1, 3'b000, -1);

      cyc();
      cyc();
      chk("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
